// File: rtl/alu_arb.sv
// Two-requester front end for a single shared combinational ALU.
// It arbitrates one operation per cycle into a one-deep result register.
package alu_arb_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } t_alu_op;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } t_rsp_state;
endpackage

module alu
  import alu_arb_pkg::*;
(
  input  t_alu_op     op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] result
);
  logic [4:0] shamt;

  // Shifts use only the low five bits of in2; all arithmetic wraps at 32 bits.
  always_comb begin
    shamt  = in2[4:0];
    result = '0;
    case (op)
      ALU_ADD:  result = in1 + in2;
      ALU_SUB:  result = in1 - in2;
      ALU_AND:  result = in1 & in2;
      ALU_OR:   result = in1 | in2;
      ALU_XOR:  result = in1 ^ in2;
      ALU_SLL:  result = in1 << shamt;
      ALU_SRL:  result = in1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(in1) >>> shamt);
      ALU_SLT:  result = {31'b0, $signed(in1) < $signed(in2)};
      ALU_SLTU: result = {31'b0, in1 < in2};
      default:  result = '0;
    endcase
  end
endmodule

module alu_arb
  import alu_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  t_alu_op     req0_op,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  t_alu_op     req1_op,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        dbg_state,
  output logic        dbg_last_grant
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a requester holds op/operands stable until it sees ready, and
  // the result stays stable while rsp_valid is high and rsp_ready is low.

  t_rsp_state  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        can_accept;
  logic        accept;
  logic        grant;
  t_alu_op     alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_res;

  // Under contention, round-robin hands the win to whoever lost last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = RR_EN ? ~last_grant_q : 1'b0;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // The register can take a new result when empty or when it drains this cycle.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || rsp_ready;
    accept     = !rst && can_accept && (req0_valid || req1_valid);
    req0_ready = accept && (grant == 1'b0);
    req1_ready = accept && (grant == 1'b1);
  end

  always_comb begin
    alu_op  = grant ? req1_op  : req0_op;
    alu_in1 = grant ? req1_in1 : req0_in1;
    alu_in2 = grant ? req1_in2 : req0_in2;
  end

  alu u_alu (
    .op     (alu_op),
    .in1    (alu_in1),
    .in2    (alu_in2),
    .result (alu_res)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      last_grant_d = grant;
      rsp_id_d     = grant;
      rsp_data_d   = alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  always_comb begin
    rsp_valid      = (state_q == ST_FULL);
    busy           = rsp_valid;
    rsp_id         = rsp_id_q;
    rsp_data       = rsp_data_q;
    dbg_state      = (state_q == ST_FULL);
    dbg_last_grant = last_grant_q;
  end
endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: a round-robin and a fixed-priority instance share stimulus;
// a queue-based reference model predicts accepts and results for each.
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  t_alu_op     req0_op, req1_op;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic        rsp_ready;

  logic        ready0_w[2];
  logic        ready1_w[2];
  logic        rsp_valid_w[2];
  logic        rsp_id_w[2];
  logic [31:0] rsp_data_w[2];
  logic        busy_w[2];
  logic        dbg_state_w[2];
  logic        dbg_last_w[2];

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  // Index 0 = round-robin instance, index 1 = fixed-priority instance.
  logic [32:0] exp_q[$];
  logic [32:0] exp_q_fp[$];
  logic        m_last[2];
  logic        acc0_seen, acc1_seen;

  alu_arb #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(ready0_w[0]), .req0_op(req0_op),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(ready1_w[0]), .req1_op(req1_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready), .rsp_id(rsp_id_w[0]),
    .rsp_data(rsp_data_w[0]), .busy(busy_w[0]),
    .dbg_state(dbg_state_w[0]), .dbg_last_grant(dbg_last_w[0])
  );

  alu_arb #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(ready0_w[1]), .req0_op(req0_op),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(ready1_w[1]), .req1_op(req1_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready), .rsp_id(rsp_id_w[1]),
    .rsp_data(rsp_data_w[1]), .busy(busy_w[1]),
    .dbg_state(dbg_state_w[1]), .dbg_last_grant(dbg_last_w[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input t_alu_op op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $unsigned($signed(a) >>> sh);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req0(input t_alu_op op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = 1'b1; req0_op = op; req0_in1 = a; req0_in2 = b;
  endtask

  task automatic set_req1(input t_alu_op op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = 1'b1; req1_op = op; req1_in1 = a; req1_in2 = b;
  endtask

  // ---------------- monitor: compare and pop ----------------
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      int          sz;
      logic [32:0] head;
      sz = (k == 0) ? exp_q.size() : exp_q_fp.size();
      if (mon_en) begin
        chk($sformatf("rsp_valid[%0d]", k), 64'(rsp_valid_w[k]), 64'(sz != 0));
        chk($sformatf("busy[%0d]", k), 64'(busy_w[k]), 64'(sz != 0));
        chk($sformatf("dbg_state[%0d]", k), 64'(dbg_state_w[k]), 64'(sz != 0));
      end
      if (sz != 0) begin
        head = (k == 0) ? exp_q[0] : exp_q_fp[0];
        if (mon_en && rsp_valid_w[k])
          chk($sformatf("rsp_id_data[%0d]", k), 64'({rsp_id_w[k], rsp_data_w[k]}), 64'(head));
        if (rsp_ready && !rst) begin
          if (k == 0) void'(exp_q.pop_front());
          else void'(exp_q_fp.pop_front());
        end
      end
    end
  end

  // ---------------- reference model: predict grant, push result ----------------
  initial begin
    m_last[0] = 1'b1;
    m_last[1] = 1'b1;
  end

  always @(negedge clk) begin
    #3;
    for (int k = 0; k < 2; k++) begin
      int          sz;
      logic        win, acc;
      logic [31:0] res;
      sz = (k == 0) ? exp_q.size() : exp_q_fp.size();
      if (req0_valid && req1_valid) win = (k == 0) ? !m_last[k] : 1'b0;
      else win = req1_valid;
      acc = !rst && (sz == 0) && (req0_valid || req1_valid);
      chk($sformatf("req0_ready[%0d]", k), 64'(ready0_w[k]), 64'(acc && !win));
      chk($sformatf("req1_ready[%0d]", k), 64'(ready1_w[k]), 64'(acc && win));
      if (rst) begin
        if (k == 0) exp_q.delete();
        else exp_q_fp.delete();
        m_last[k] = 1'b1;
      end else if (acc) begin
        res = win ? alu_ref(req1_op, req1_in1, req1_in2) : alu_ref(req0_op, req0_in1, req0_in2);
        if (k == 0) exp_q.push_back({win, res});
        else exp_q_fp.push_back({win, res});
        m_last[k] = win;
      end
    end
    acc0_seen = ready0_w[0];
    acc1_seen = ready1_w[0];
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_in1 = '0; req0_in2 = '0;
    req1_valid = 1'b1; req1_op = ALU_ADD; req1_in1 = '0; req1_in2 = '0;
    cyc(); #4;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset rsp_valid[%0d]", k), 64'(rsp_valid_w[k]), 64'd0);
      chk($sformatf("reset rsp_id[%0d]", k), 64'(rsp_id_w[k]), 64'd0);
      chk($sformatf("reset rsp_data[%0d]", k), 64'(rsp_data_w[k]), 64'd0);
      chk($sformatf("reset last_grant[%0d]", k), 64'(dbg_last_w[k]), 64'd1);
      chk($sformatf("reset readies[%0d]", k), 64'({ready0_w[k], ready1_w[k]}), 64'd0);
    end
    cyc(); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; mon_en = 1'b1;

    // single requester ADD
    cyc(); set_req0(ALU_ADD, 32'd10, 32'd5); rsp_ready = 1'b1;
    cyc(); req0_valid = 1'b0; #4;
    chk("add rsp_valid", 64'(rsp_valid_w[0]), 64'd1);
    chk("add rsp_id", 64'(rsp_id_w[0]), 64'd0);
    chk("add rsp_data", 64'(rsp_data_w[0]), 64'd15);

    // contention right after reset: requester 0 first, then 1
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    set_req0(ALU_ADD, 32'd10, 32'd5); set_req1(ALU_SUB, 32'd10, 32'd5);
    cyc(); req0_valid = 1'b0; #4;
    chk("rr first id", 64'(rsp_id_w[0]), 64'd0);
    chk("rr first data", 64'(rsp_data_w[0]), 64'd15);
    cyc(); req1_valid = 1'b0; #4;
    chk("rr second id", 64'(rsp_id_w[0]), 64'd1);
    chk("rr second data", 64'(rsp_data_w[0]), 64'd5);

    // six cycles of continuous contention
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    set_req0(ALU_ADD, 32'd100, 32'd1); set_req1(ALU_ADD, 32'd200, 32'd2);
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 5) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #4;
      chk($sformatf("rr seq id %0d", i), 64'(rsp_id_w[0]), 64'(i % 2));
      chk($sformatf("fp seq id %0d", i), 64'(rsp_id_w[1]), 64'd0);
    end

    // stall with a held SRA result, then back-to-back accept
    cyc(); set_req1(ALU_SRA, 32'hFFFF_FFF8, 32'd2); rsp_ready = 1'b0;
    cyc(); req1_valid = 1'b0; set_req0(ALU_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      #4;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stall data[%0d] c%0d", k, i), 64'(rsp_data_w[k]), 64'hFFFF_FFFE);
        chk($sformatf("stall id[%0d] c%0d", k, i), 64'(rsp_id_w[k]), 64'd1);
        chk($sformatf("stall readies[%0d] c%0d", k, i), 64'({ready0_w[k], ready1_w[k]}), 64'd0);
      end
    end
    cyc(); rsp_ready = 1'b1; #4;
    chk("b2b ready0", 64'(ready0_w[0]), 64'd1);
    chk("b2b data held", 64'(rsp_data_w[0]), 64'hFFFF_FFFE);
    cyc(); req0_valid = 1'b0; #4;
    chk("b2b next data", 64'(rsp_data_w[0]), 64'd2);
    chk("b2b next id", 64'(rsp_id_w[0]), 64'd0);

    // reset discards a pending result
    cyc(); set_req0(ALU_SLTU, 32'hFFFF_FFFF, 32'd1); rsp_ready = 1'b0;
    cyc(); req0_valid = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0; set_req1(ALU_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F); rsp_ready = 1'b1; #4;
    chk("post-reset rsp_valid", 64'(rsp_valid_w[0]), 64'd0);
    chk("resume ready1", 64'(ready1_w[0]), 64'd1);
    cyc(); req1_valid = 1'b0; #4;
    chk("xor rsp_id", 64'(rsp_id_w[0]), 64'd1);
    chk("xor rsp_data", 64'(rsp_data_w[0]), 64'hFFFF_FFFF);
    chk("xor last_grant", 64'(dbg_last_w[0]), 64'd1);
    chk("xor last_grant fp", 64'(dbg_last_w[1]), 64'd1);

    // randomized traffic; requesters hold until the round-robin instance accepts
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (!req0_valid || acc0_seen) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op = t_alu_op'(4'($urandom_range(0, 9)));
        req0_in1 = pick32(); req0_in2 = pick32();
      end
      if (!req1_valid || acc1_seen) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op = t_alu_op'(4'($urandom_range(0, 9)));
        req1_in1 = pick32(); req1_in2 = pick32();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    cyc(); req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) cyc();
    #4;
    chk("drain rr", 64'(exp_q.size()), 64'd0);
    chk("drain fp", 64'(exp_q_fp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
